// File: rtl/rot_serializer_if.sv
// Handshake bundle for rot_serializer: parallel word input, serial bit output,
// and FIFO occupancy. The slave modport is the serializer's view.
interface rot_serializer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             serial_o;
  logic             serial_valid_o;
  logic             sof_o;
  logic             ser_ready_i;
  logic [CNTW-1:0]  count_o;

  modport slave (
    input  data_i, valid_i, ser_ready_i,
    output ready_o, serial_o, serial_valid_o, sof_o, count_o
  );

  modport master (
    output data_i, valid_i, ser_ready_i,
    input  ready_o, serial_o, serial_valid_o, sof_o, count_o
  );
endinterface

// File: rtl/rot_serializer.sv
// Word FIFO followed by a parallel-to-serial shifter with downstream stall.
// Define ROT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module rot_serializer #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rot_serializer_if.slave bus
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

`ifdef ROT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic             serial_reg, serial_valid_reg, sof_reg;
`ifdef ROT_SERIALIZER_PARITY_EN
  logic             parity_reg;
`endif

  logic             ready, push, pop, fifo_nonempty, last_bit;
  logic [WIDTH-1:0] head_word, shifted;
  logic             load_head, shift_head;

  assign ready         = (count_reg != FULL_CNT);
  assign push          = bus.valid_i && ready;
  assign fifo_nonempty = (count_reg != '0);
  assign last_bit      = (bit_cnt_reg == LAST_BIT);
  assign head_word     = mem[rd_ptr_reg];

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted    = shift_reg << 1;
      assign load_head  = head_word[WIDTH-1];
      assign shift_head = shifted[WIDTH-1];
    end else begin : g_lsb
      assign shifted    = shift_reg >> 1;
      assign load_head  = head_word[0];
      assign shift_head = shifted[0];
    end
  endgenerate

  // Single source of truth for "FSM takes the head word this edge".
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      IDLE:  pop = fifo_nonempty;
`ifndef ROT_SERIALIZER_PARITY_EN
      SHIFT: pop = bus.ser_ready_i && last_bit && fifo_nonempty;
`else
      PAR:   pop = bus.ser_ready_i && fifo_nonempty;
`endif
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= bus.data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      shift_reg        <= '0;
      bit_cnt_reg      <= '0;
      serial_reg       <= 1'b0;
      serial_valid_reg <= 1'b0;
      sof_reg          <= 1'b0;
`ifdef ROT_SERIALIZER_PARITY_EN
      parity_reg       <= 1'b0;
`endif
    end else if (pop) begin
      // Every path that pops lands in SHIFT with the new word's first bit.
      state_reg        <= SHIFT;
      shift_reg        <= head_word;
      bit_cnt_reg      <= '0;
      serial_reg       <= load_head;
      serial_valid_reg <= 1'b1;
      sof_reg          <= 1'b1;
`ifdef ROT_SERIALIZER_PARITY_EN
      parity_reg       <= ^head_word;
`endif
    end else begin
      case (state_reg)
        SHIFT: begin
          if (bus.ser_ready_i) begin
            if (!last_bit) begin
              shift_reg   <= shifted;
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
              serial_reg  <= shift_head;
              sof_reg     <= 1'b0;
            end else begin
`ifdef ROT_SERIALIZER_PARITY_EN
              state_reg  <= PAR;
              serial_reg <= parity_reg;
              sof_reg    <= 1'b0;
`else
              state_reg        <= IDLE;
              serial_reg       <= 1'b0;
              serial_valid_reg <= 1'b0;
              sof_reg          <= 1'b0;
`endif
            end
          end
        end
`ifdef ROT_SERIALIZER_PARITY_EN
        PAR: begin
          if (bus.ser_ready_i) begin
            state_reg        <= IDLE;
            serial_reg       <= 1'b0;
            serial_valid_reg <= 1'b0;
            sof_reg          <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  assign bus.ready_o        = ready;
  assign bus.count_o        = count_reg;
  assign bus.serial_o       = serial_reg;
  assign bus.serial_valid_o = serial_valid_reg;
  assign bus.sof_o          = sof_reg;
endmodule
